// File: rtl/line_follower_pkg.sv
// Shared constants for the line follower steering datapath.
// State encodings, side flags and default duty values.
package line_follower_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FORWARD = 3'd1,
    S_TURN_L  = 3'd2,
    S_TURN_R  = 3'd3,
    S_SEARCH  = 3'd4,
    S_HALT    = 3'd5
  } state_e;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  localparam logic [7:0]  DUTY_FAST_DEF    = 8'd200;
  localparam logic [7:0]  DUTY_SLOW_DEF    = 8'd60;
  localparam logic [23:0] LOST_TIMEOUT_DEF = 24'd5000000;

  // Target state for a sensor pattern; 000 maps to SEARCH.
  function automatic state_e classify(
    input logic [2:0] s,
    input state_e     cur
  );
    state_e r;
    unique case (s)
      3'b010, 3'b111: r = S_FORWARD;
      3'b100, 3'b110: r = S_TURN_L;
      3'b001, 3'b011: r = S_TURN_R;
      3'b101:  r = (cur == S_IDLE) ? S_FORWARD : cur;
      default: r = S_SEARCH;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output with its own free-running counter.
// The duty is sampled only at counter wrap so periods stay whole.
module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] duty_q;
  logic                pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (&cnt_q) duty_q <= duty;
      pwm_q <= (cnt_q < duty_q);
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/line_steer_controller.sv
// Steering FSM: classifies the three line sensors and
// drives two PWM motor channels with direction bits.
module line_steer_controller
  import line_follower_pkg::*;
#(
  parameter int                PWM_BITS     = 8,
  parameter logic [PWM_BITS-1:0] DUTY_FAST  = DUTY_FAST_DEF,
  parameter logic [PWM_BITS-1:0] DUTY_SLOW  = DUTY_SLOW_DEF,
  parameter logic [23:0]       LOST_TIMEOUT = LOST_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sens_l,
  input  logic       sens_c,
  input  logic       sens_r,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic [2:0] state_dbg,
  output logic       lost
);

  logic [2:0]          sens_q;
  state_e              state_q, state_d;
  logic                side_q, side_d;
  logic [23:0]         cnt_q, cnt_d;
  logic                dir_l_q, dir_l_d;
  logic                dir_r_q, dir_r_d;
  logic                lost_q, lost_d;
  logic [PWM_BITS-1:0] duty_l_q, duty_l_d;
  logic [PWM_BITS-1:0] duty_r_q, duty_r_d;

  always_comb begin
    state_d = classify(sens_q, state_q);
    side_d  = side_q;
    cnt_d   = '0;
    if (!enable) begin
      state_d = S_IDLE;
    end else if (sens_q == 3'b000) begin
      unique case (state_q)
        S_HALT: state_d = S_HALT;
        S_SEARCH: begin
          if (cnt_q == LOST_TIMEOUT - 24'd1) begin
            state_d = S_HALT;
          end else begin
            state_d = S_SEARCH;
            cnt_d   = cnt_q + 24'd1;
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
    if (state_d == S_TURN_L) side_d = SIDE_LEFT;
    if (state_d == S_TURN_R) side_d = SIDE_RIGHT;
  end

  always_comb begin
    duty_l_d = '0;
    duty_r_d = '0;
    dir_l_d  = 1'b1;
    dir_r_d  = 1'b1;
    lost_d   = 1'b0;
    unique case (state_d)
      S_FORWARD: begin
        duty_l_d = DUTY_FAST;
        duty_r_d = DUTY_FAST;
      end
      S_TURN_L: begin
        duty_l_d = DUTY_SLOW;
        duty_r_d = DUTY_FAST;
      end
      S_TURN_R: begin
        duty_l_d = DUTY_FAST;
        duty_r_d = DUTY_SLOW;
      end
      S_SEARCH: begin
        duty_l_d = DUTY_SLOW;
        duty_r_d = DUTY_SLOW;
        dir_l_d  = (side_d == SIDE_RIGHT);
        dir_r_d  = (side_d == SIDE_LEFT);
        lost_d   = 1'b1;
      end
      S_HALT:  lost_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sens_q   <= 3'b000;
      state_q  <= S_IDLE;
      side_q   <= SIDE_LEFT;
      cnt_q    <= '0;
      dir_l_q  <= 1'b1;
      dir_r_q  <= 1'b1;
      lost_q   <= 1'b0;
      duty_l_q <= '0;
      duty_r_q <= '0;
    end else begin
      sens_q   <= {sens_l, sens_c, sens_r};
      state_q  <= state_d;
      side_q   <= side_d;
      cnt_q    <= cnt_d;
      dir_l_q  <= dir_l_d;
      dir_r_q  <= dir_r_d;
      lost_q   <= lost_d;
      duty_l_q <= duty_l_d;
      duty_r_q <= duty_r_d;
    end
  end

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_l (
    .clk     (clk),
    .rst_n   (rst_n),
    .duty    (duty_l_q),
    .pwm_out (pwm_l)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .duty    (duty_r_q),
    .pwm_out (pwm_r)
  );

  assign dir_l     = dir_l_q;
  assign dir_r     = dir_r_q;
  assign lost      = lost_q;
  assign state_dbg = state_q;

endmodule
